mem_writeback: RTL and testbench
================================

Name: mem_writeback

Overview:
- Back half of the pipeline: consumes the operand/control bundle produced by execute and performs the data-memory access.
- Closes the loop into the register file: wEn/write address/wData, plus the stack-pointer update.
- Runs a valid/ready handshake upstream and a req/gnt + rvalid handshake to data memory.
- Stalls execute while a memory access is outstanding.

Parameters:
- STACK_TOP, 32'h0000_FFFC, reset value of SPout.
- TIMEOUT, 16, cycles allowed in MEM_REQ+MEM_WAIT before abort (only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute bundle valid.
- in_ready  out  1  block can accept bundle.
- alu_result  in  32  ALU result / memory word address.
- store_data  in  32  data for stores.
- rx_field  in  5  destination register field.
- reg_we  in  1  instruction writes a register.
- memrd  in  1  load.
- memwr  in  1  store.
- wbdata_sel  in  1  0 = alu_result, 1 = load data.
- wbreg_sel  in  1  0 = rx_field, 1 = LR (5'b11110).
- SPwe_in  in  1  commit SP update.
- SPin  in  32  new SP value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  write data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- wEn  out  1  register-file write strobe.
- wAddr  out  5  register-file write address.
- wData  out  32  register-file write data.
- SPwe_o  out  1  SP-update pulse.
- SPout  out  32  current stack pointer.
- stall  out  1  equals ~in_ready.

Behaviour:
- Reset (rst high at clk edge):
  - state = IDLE.
  - wEn = 0, wAddr = 0, wData = 0.
  - dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0.
  - SPwe_o = 0, SPout = STACK_TOP.
  - Any in-flight access is abandoned.
  - dmem_rvalid is ignored in IDLE, so a response arriving after reset is discarded.
- Accept: in_valid & in_ready at a clk edge. in_ready = (state == IDLE).
- Destination address: dest = wbreg_sel ? 5'b11110 : rx_field.
- IDLE, accepted with memrd = memwr = 0:
  - Next cycle: wEn = reg_we, wAddr = dest, wData = alu_result.
  - State stays IDLE, so back-to-back ALU ops run at 1 per cycle with 1-cycle latency.
- IDLE, accepted with memrd or memwr:
  - Latch dest, reg_we, wbdata_sel and the SP fields.
  - Go to MEM_REQ; next cycle dmem_req = 1, dmem_we = memwr, dmem_addr = alu_result, dmem_wdata = store_data.
  - memrd and memwr both set: treated as store.
- MEM_REQ:
  - Hold dmem_* stable until dmem_gnt.
  - On gnt for a store: dmem_req drops next cycle and the state returns to IDLE. If reg_we, a write of alu_result is issued in that cycle (post-increment addressing).
  - On gnt for a load: go to MEM_WAIT, dmem_req drops.
- MEM_WAIT:
  - On dmem_rvalid: next cycle wEn = reg_we, wAddr = dest, wData = wbdata_sel ? dmem_rdata : latched alu_result.
  - Then return to IDLE.
- dmem_rvalid is sampled only in MEM_WAIT. The responder must not assert rvalid in the gnt cycle.
- wEn and SPwe_o are single-cycle pulses; wAddr and wData hold their last values otherwise.
- SP update:
  - SPout <= SPin and SPwe_o pulses in the same cycle as the instruction's register write slot.
  - ALU ops: cycle after accept. Stores: cycle after gnt. Loads: cycle after rvalid.
  - SPwe_in = 0 leaves SPout unchanged.
- A register write and an SP write in the same cycle are both performed.
- Load latency from accept: 1 (request) + gnt wait + rvalid wait + 1.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering MEM_REQ and increments each cycle in MEM_REQ/MEM_WAIT.
  - When it reaches TIMEOUT: drop dmem_req, return to IDLE, suppress wEn and SPwe_o for that instruction.
  - Set extra output port mem_err (1 bit), which is sticky until rst.
  - Late gnt/rvalid is ignored.
- Undefined: no counter and no mem_err port; the block waits indefinitely.

Test Plan:
- Reset: rst high 2 cycles -> SPout = 32'h0000_FFFC, wEn = 0, dmem_req = 0, in_ready = 1.
- Back-to-back ALU ops, rx 3/4/5, results 0x11/0x22/0x33 -> wEn high 3 consecutive cycles, wAddr 3/4/5, wData 0x11/0x22/0x33, stall never high.
- Load, addr 0x40, wbreg_sel = 0, rx = 7, gnt after 2 cycles, rvalid 3 cycles later with 0xCAFEF00D:
  - dmem_addr = 0x40 and dmem_we = 0 held until gnt.
  - wEn with wAddr = 7 and wData = 0xCAFEF00D one cycle after rvalid.
  - stall high throughout.
- Store with SPwe_in = 1, SPin = 0xFFF8, store_data 0x1234, addr 0x80, gnt immediate:
  - dmem_we = 1, dmem_wdata = 0x1234.
  - SPwe_o pulse, SPout = 0xFFF8 cycle after gnt, no wEn.
- rst asserted while in MEM_WAIT, then rvalid arrives -> state IDLE, no wEn, in_ready = 1 next cycle.
- MEM_TIMEOUT_EN, TIMEOUT = 16, gnt never asserted -> dmem_req drops after 16 cycles, mem_err = 1, no wEn, in_ready = 1.

Source files
------------

// File: rtl/mem_writeback.sv
// Memory/write-back stage: data-memory access (req/gnt + rvalid), register-file write and SP update.
// Optional macro MEM_TIMEOUT_EN adds an access timeout with a sticky mem_err output.
module mem_writeback #(
    parameter logic [31:0] STACK_TOP = 32'h0000_FFFC,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rx_field,
    input  logic        reg_we,
    input  logic        memrd,
    input  logic        memwr,
    input  logic        wbdata_sel,
    input  logic        wbreg_sel,
    input  logic        SPwe_in,
    input  logic [31:0] SPin,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wEn,
    output logic [4:0]  wAddr,
    output logic [31:0] wData,
    output logic        SPwe_o,
    output logic [31:0] SPout,
`ifdef MEM_TIMEOUT_EN
    output logic        mem_err,
`endif
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        wen_q, wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sp_we_q, sp_we_d;
    logic [31:0] sp_q, sp_d;
    logic        req_q, req_d;
    logic        dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [4:0]  lat_dest_q, lat_dest_d;
    logic        lat_we_q, lat_we_d;
    logic        lat_sel_q, lat_sel_d;
    logic        lat_sp_we_q, lat_sp_we_d;
    logic [31:0] lat_sp_q, lat_sp_d;

    logic [4:0]  dest_s;
    logic        timeout_s;

    assign dest_s   = wbreg_sel ? 5'b11110 : rx_field;
    assign in_ready = (state_q == IDLE);
    assign stall    = ~in_ready;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    assign timeout_s = (state_q != IDLE) && ((cnt_q + 16'd1) == TIMEOUT_W);
    assign mem_err   = err_q;

    // Access-age counter and sticky error flag
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        if (timeout_s && !((state_q == MEM_REQ && dmem_gnt) || (state_q == MEM_WAIT && dmem_rvalid))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Timeout state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; a completing handshake wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid && (memrd || memwr)) state_d = MEM_REQ;
                else                              state_d = IDLE;
            end
            MEM_REQ: begin
                if (dmem_gnt)       state_d = dwe_q ? IDLE : MEM_WAIT;
                else if (timeout_s) state_d = IDLE;
                else                state_d = MEM_REQ;
            end
            MEM_WAIT: begin
                if (dmem_rvalid || timeout_s) state_d = IDLE;
                else                          state_d = MEM_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; wEn and SPwe_o default low so they pulse
    always_comb begin
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        sp_we_d     = 1'b0;
        sp_d        = sp_q;
        req_d       = req_q;
        dwe_d       = dwe_q;
        daddr_d     = daddr_q;
        dwdata_d    = dwdata_q;
        lat_dest_d  = lat_dest_q;
        lat_we_d    = lat_we_q;
        lat_sel_d   = lat_sel_q;
        lat_sp_we_d = lat_sp_we_q;
        lat_sp_d    = lat_sp_q;
        case (state_q)
            IDLE: begin
                if (in_valid && (memrd || memwr)) begin
                    req_d       = 1'b1;
                    dwe_d       = memwr;
                    daddr_d     = alu_result;
                    dwdata_d    = store_data;
                    lat_dest_d  = dest_s;
                    lat_we_d    = reg_we;
                    lat_sel_d   = wbdata_sel;
                    lat_sp_we_d = SPwe_in;
                    lat_sp_d    = SPin;
                end else if (in_valid) begin
                    wen_d   = reg_we;
                    waddr_d = dest_s;
                    wdata_d = alu_result;
                    sp_we_d = SPwe_in;
                    sp_d    = SPwe_in ? SPin : sp_q;
                end else begin
                    req_d = 1'b0;
                end
            end
            MEM_REQ: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (dwe_q) begin
                        // daddr_q still holds the latched alu_result (post-increment write-back)
                        wen_d   = lat_we_q;
                        waddr_d = lat_dest_q;
                        wdata_d = daddr_q;
                        sp_we_d = lat_sp_we_q;
                        sp_d    = lat_sp_we_q ? lat_sp_q : sp_q;
                    end else begin
                        wen_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    req_d = 1'b0;
                end else begin
                    req_d = 1'b1;
                end
            end
            MEM_WAIT: begin
                req_d = 1'b0;
                if (dmem_rvalid) begin
                    wen_d   = lat_we_q;
                    waddr_d = lat_dest_q;
                    wdata_d = lat_sel_q ? dmem_rdata : daddr_q;
                    sp_we_d = lat_sp_we_q;
                    sp_d    = lat_sp_we_q ? lat_sp_q : sp_q;
                end else begin
                    wen_d = 1'b0;
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wen_q       <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            sp_we_q     <= 1'b0;
            sp_q        <= STACK_TOP;
            req_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= 32'd0;
            dwdata_q    <= 32'd0;
            lat_dest_q  <= 5'd0;
            lat_we_q    <= 1'b0;
            lat_sel_q   <= 1'b0;
            lat_sp_we_q <= 1'b0;
            lat_sp_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            sp_we_q     <= sp_we_d;
            sp_q        <= sp_d;
            req_q       <= req_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            dwdata_q    <= dwdata_d;
            lat_dest_q  <= lat_dest_d;
            lat_we_q    <= lat_we_d;
            lat_sel_q   <= lat_sel_d;
            lat_sp_we_q <= lat_sp_we_d;
            lat_sp_q    <= lat_sp_d;
        end
    end

    assign wEn        = wen_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign SPwe_o     = sp_we_q;
    assign SPout      = sp_q;
    assign dmem_req   = req_q;
    assign dmem_we    = dwe_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = dwdata_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: ALU vector table plus load/store/reset(/timeout) sequences.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result, store_data, SPin, dmem_addr, dmem_wdata, dmem_rdata, wData, SPout;
    logic [4:0]  rx_field, wAddr;
    logic        reg_we, memrd, memwr, wbdata_sel, wbreg_sel, SPwe_in;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, wEn, SPwe_o, stall;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .rx_field(rx_field),
        .reg_we(reg_we), .memrd(memrd), .memwr(memwr), .wbdata_sel(wbdata_sel),
        .wbreg_sel(wbreg_sel), .SPwe_in(SPwe_in), .SPin(SPin),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wEn(wEn), .wAddr(wAddr), .wData(wData),
        .SPwe_o(SPwe_o), .SPout(SPout),
`ifdef MEM_TIMEOUT_EN
        .mem_err(mem_err),
`endif
        .stall(stall)
    );

    typedef struct {
        logic [4:0]  rx;
        logic        we;
        logic        bsel;
        logic [31:0] alu;
        logic        spwe;
        logic [31:0] spin;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_spwe;
        logic [31:0] exp_sp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; alu_result = 32'd0; store_data = 32'd0; rx_field = 5'd0;
        reg_we = 1'b0; memrd = 1'b0; memwr = 1'b0; wbdata_sel = 1'b0; wbreg_sel = 1'b0;
        SPwe_in = 1'b0; SPin = 32'd0;
    endtask

    initial begin
        vecs[0] = '{5'd3, 1'b1, 1'b0, 32'h11, 1'b0, 32'h0,    1'b1, 5'd3,  32'h11, 1'b0, 32'h0000_FFFC};
        vecs[1] = '{5'd4, 1'b1, 1'b0, 32'h22, 1'b0, 32'h0,    1'b1, 5'd4,  32'h22, 1'b0, 32'h0000_FFFC};
        vecs[2] = '{5'd5, 1'b1, 1'b0, 32'h33, 1'b0, 32'h0,    1'b1, 5'd5,  32'h33, 1'b0, 32'h0000_FFFC};
        vecs[3] = '{5'd2, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0,    1'b1, 5'd30, 32'h44, 1'b0, 32'h0000_FFFC};
        vecs[4] = '{5'd6, 1'b0, 1'b0, 32'h55, 1'b1, 32'h1000, 1'b0, 5'd6,  32'h55, 1'b1, 32'h0000_1000};
        vecs[5] = '{5'd9, 1'b1, 1'b0, 32'h66, 1'b1, 32'h2000, 1'b1, 5'd9,  32'h66, 1'b1, 32'h0000_2000};

        idle_inputs();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_sp",    SPout, 32'h0000_FFFC);
        check("reset_wen",   {31'd0, wEn}, 32'd0);
        check("reset_req",   {31'd0, dmem_req}, 32'd0);
        check("reset_ready", {31'd0, in_ready}, 32'd1);
        check("reset_addr",  dmem_addr, 32'd0);
`ifdef MEM_TIMEOUT_EN
        check("reset_err",   {31'd0, mem_err}, 32'd0);
`endif

        // Back-to-back ALU ops, one accepted per cycle
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; rx_field = vecs[i].rx; reg_we = vecs[i].we; wbreg_sel = vecs[i].bsel;
            alu_result = vecs[i].alu; SPwe_in = vecs[i].spwe; SPin = vecs[i].spin;
            check("alu_stall", {31'd0, stall}, 32'd0);
            tick();
            check("alu_wen", {31'd0, wEn}, {31'd0, vecs[i].exp_wen});
            if (vecs[i].exp_wen) begin
                check("alu_waddr", {27'd0, wAddr}, {27'd0, vecs[i].exp_waddr});
                check("alu_wdata", wData, vecs[i].exp_wdata);
            end
            check("alu_spwe", {31'd0, SPwe_o}, {31'd0, vecs[i].exp_spwe});
            check("alu_sp", SPout, vecs[i].exp_sp);
        end
        idle_inputs();
        tick();
        check("idle_wen",  {31'd0, wEn}, 32'd0);
        check("idle_spwe", {31'd0, SPwe_o}, 32'd0);
        check("idle_sp",   SPout, 32'h0000_2000);

        // Load: gnt after 2 cycles, rvalid 3 cycles later
        in_valid = 1'b1; memrd = 1'b1; alu_result = 32'h40; rx_field = 5'd7; reg_we = 1'b1; wbdata_sel = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            check("ld_req",   {31'd0, dmem_req}, 32'd1);
            check("ld_we",    {31'd0, dmem_we}, 32'd0);
            check("ld_addr",  dmem_addr, 32'h40);
            check("ld_stall", {31'd0, stall}, 32'd1);
            if (c == 1) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("ld_wait_req",   {31'd0, dmem_req}, 32'd0);
            check("ld_wait_wen",   {31'd0, wEn}, 32'd0);
            check("ld_wait_stall", {31'd0, stall}, 32'd1);
            if (c == 2) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D; end
            tick();
        end
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        check("ld_wen",   {31'd0, wEn}, 32'd1);
        check("ld_waddr", {27'd0, wAddr}, 32'd7);
        check("ld_wdata", wData, 32'hCAFE_F00D);
        check("ld_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("ld_wen_pulse", {31'd0, wEn}, 32'd0);

        // Store with SP update, gnt in first request cycle
        in_valid = 1'b1; memwr = 1'b1; alu_result = 32'h80; store_data = 32'h1234;
        SPwe_in = 1'b1; SPin = 32'h0000_FFF8;
        tick();
        idle_inputs();
        check("st_req",   {31'd0, dmem_req}, 32'd1);
        check("st_we",    {31'd0, dmem_we}, 32'd1);
        check("st_wdata", dmem_wdata, 32'h1234);
        check("st_addr",  dmem_addr, 32'h80);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("st_req_drop", {31'd0, dmem_req}, 32'd0);
        check("st_spwe",     {31'd0, SPwe_o}, 32'd1);
        check("st_sp",       SPout, 32'h0000_FFF8);
        check("st_nowen",    {31'd0, wEn}, 32'd0);
        check("st_ready",    {31'd0, in_ready}, 32'd1);
        tick();
        check("st_spwe_pulse", {31'd0, SPwe_o}, 32'd0);

        // Store with register write-back of the address (post-increment form)
        in_valid = 1'b1; memwr = 1'b1; alu_result = 32'h90; store_data = 32'h5; reg_we = 1'b1; rx_field = 5'd10;
        tick();
        idle_inputs();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("stwb_wen",   {31'd0, wEn}, 32'd1);
        check("stwb_waddr", {27'd0, wAddr}, 32'd10);
        check("stwb_wdata", wData, 32'h90);

        // Reset while in MEM_WAIT, then a stale rvalid
        in_valid = 1'b1; memrd = 1'b1; alu_result = 32'hA0; reg_we = 1'b1; rx_field = 5'd12; wbdata_sel = 1'b1;
        tick();
        idle_inputs();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("rw_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_ready", {31'd0, in_ready}, 32'd1);
        check("rw_sp",    SPout, 32'h0000_FFFC);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        check("rw_nowen",  {31'd0, wEn}, 32'd0);
        check("rw_ready2", {31'd0, in_ready}, 32'd1);
        check("rw_req",    {31'd0, dmem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Timeout: gnt never arrives
        begin
            int n;
            in_valid = 1'b1; memrd = 1'b1; alu_result = 32'hB0; reg_we = 1'b1; rx_field = 5'd13;
            tick();
            idle_inputs();
            n = 0;
            while (dmem_req && n < 40) begin
                n++;
                check("to_nowen", {31'd0, wEn}, 32'd0);
                tick();
            end
            check("to_req_cycles", n, 32'd16);
            check("to_err",   {31'd0, mem_err}, 32'd1);
            check("to_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("to_nowen_after", {31'd0, wEn}, 32'd0);
            check("to_err_sticky",  {31'd0, mem_err}, 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
